coreahbltoaxi_rdch_fifo: RTL and testbench

//  Parametrised single-clock read-data FIFO for the AHB-Lite-to-AXI read channel.

---
 rtl/coreahbltoaxi_rdch_pkg.sv | 17 +
 rtl/coreahbltoaxi_rdch_dpram.sv | 37 +++
 rtl/coreahbltoaxi_rdch_fifo.sv | 109 ++++++++++
 tb/tb_coreahbltoaxi_rdch_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/coreahbltoaxi_rdch_pkg.sv
// Shared constants and helpers for the AHB-Lite-to-AXI read-data FIFO.
// Error-flag logic is controlled by the macro COREAHBLTOAXI_RDCH_FIFO_ERR_EN.
package coreahbltoaxi_rdch_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 4;
   localparam int DEF_AFULL_LEVEL = 2;
   localparam int DEF_PTR_WIDTH   = DEF_ADDR_WIDTH + 1;

   // Value driven onto read data at reset and whenever no read is accepted
   localparam logic RST_DATA_BIT = 1'b0;

   function automatic int fifo_depth(input int addr_width);
      return 2 ** addr_width;
   endfunction

endpackage

// File: rtl/coreahbltoaxi_rdch_dpram.sv
// DEPTH x DATA_WIDTH RAM: synchronous write port, synchronous read port whose
// output is forced to zero when read-enable is low or clr is asserted.
module coreahbltoaxi_rdch_dpram
   import coreahbltoaxi_rdch_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (clr || !re) begin
         rdata <= {DATA_WIDTH{RST_DATA_BIT}};
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/coreahbltoaxi_rdch_fifo.sv
// Single-clock read-data FIFO: pointers, registered occupancy/flags, 1-cycle read.
// Define COREAHBLTOAXI_RDCH_FIFO_ERR_EN to build the sticky OVF_ERR/UDF_ERR flags.
module coreahbltoaxi_rdch_fifo
   import coreahbltoaxi_rdch_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int AFULL_LEVEL = DEF_AFULL_LEVEL
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  WE,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  RE,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  RVALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVF_ERR,
   output logic                  UDF_ERR
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_V = PW'(AFULL_LEVEL);

   logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
   logic [PW-1:0] count_nxt;
   logic          wr_acc, rd_acc;

   // Acceptance uses the registered flags, i.e. the state before this edge
   assign wr_acc = WE && !FULL;
   assign rd_acc = RE && !EMPTY;

   always_comb begin
      wptr_nxt  = wptr;
      rptr_nxt  = rptr;
      count_nxt = COUNT;
      if (wr_acc) begin
         wptr_nxt = wptr + PW'(1);
      end
      if (rd_acc) begin
         rptr_nxt = rptr + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
         count_nxt = COUNT + PW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = COUNT - PW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr        <= '0;
         rptr        <= '0;
         COUNT       <= '0;
         EMPTY       <= 1'b1;
         FULL        <= 1'b0;
         ALMOST_FULL <= 1'b0;
         RVALID      <= 1'b0;
      end else begin
         wptr        <= wptr_nxt;
         rptr        <= rptr_nxt;
         COUNT       <= count_nxt;
         EMPTY       <= (wptr_nxt == rptr_nxt);
         FULL        <= (wptr_nxt[PW-1] != rptr_nxt[PW-1]) &&
                        (wptr_nxt[PW-2:0] == rptr_nxt[PW-2:0]);
         ALMOST_FULL <= ((DEPTH_V - count_nxt) <= AFULL_V);
         RVALID      <= rd_acc;
      end
   end

   coreahbltoaxi_rdch_dpram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .CLK   (CLK),
      .clr   (RESET),
      .we    (wr_acc && !RESET),
      .waddr (wptr[PW-2:0]),
      .wdata (WDATA),
      .re    (rd_acc),
      .raddr (rptr[PW-2:0]),
      .rdata (RDATA)
   );

`ifdef COREAHBLTOAXI_RDCH_FIFO_ERR_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OVF_ERR <= 1'b0;
         UDF_ERR <= 1'b0;
      end else begin
         if (WE && FULL) begin
            OVF_ERR <= 1'b1;
         end
         if (RE && EMPTY) begin
            UDF_ERR <= 1'b1;
         end
      end
   end
`else
   assign OVF_ERR = 1'b0;
   assign UDF_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_coreahbltoaxi_rdch_fifo.sv
// Directed bench for coreahbltoaxi_rdch_fifo: vector table plus corner-case sequences.
module tb_coreahbltoaxi_rdch_fifo;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        WE;
   logic [31:0] WDATA;
   logic        RE;
   logic [31:0] RDATA;
   logic        RVALID, FULL, EMPTY, ALMOST_FULL, OVF_ERR, UDF_ERR;
   logic [4:0]  COUNT;

   int n_checks = 0;
   int n_errors = 0;

`ifdef COREAHBLTOAXI_RDCH_FIFO_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   always #5 CLK = ~CLK;

   coreahbltoaxi_rdch_fifo dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .WE          (WE),
      .WDATA       (WDATA),
      .RE          (RE),
      .RDATA       (RDATA),
      .RVALID      (RVALID),
      .FULL        (FULL),
      .EMPTY       (EMPTY),
      .ALMOST_FULL (ALMOST_FULL),
      .COUNT       (COUNT),
      .OVF_ERR     (OVF_ERR),
      .UDF_ERR     (UDF_ERR)
   );

   typedef struct {
      logic        we;
      logic [31:0] wdata;
      logic        re;
      logic [31:0] rdata;
      logic        rvalid;
      logic [4:0]  count;
      logic        empty;
      logic        full;
      logic        afull;
   } vec_t;

   vec_t vecs [33];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic we, input logic [31:0] wd, input logic re);
      WE = we; WDATA = wd; RE = re;
      @(posedge CLK);
      #1;
      WE = 1'b0; RE = 1'b0; WDATA = '0;
   endtask

   task automatic check_state(input string tag, input logic [31:0] rd, input logic rv,
                              input logic [4:0] cnt, input logic emp, input logic fl);
      check({tag, ".rdata"}, RDATA, rd);
      check({tag, ".rvalid"}, 32'(RVALID), 32'(rv));
      check({tag, ".count"}, 32'(COUNT), 32'(cnt));
      check({tag, ".empty"}, 32'(EMPTY), 32'(emp));
      check({tag, ".full"}, 32'(FULL), 32'(fl));
   endtask

   initial begin
      // Fill 16, one dropped write, drain 16
      for (int i = 0; i < 16; i++) begin
         vecs[i] = '{we: 1'b1, wdata: 32'h1000_0000 + 32'(i), re: 1'b0,
                     rdata: 32'h0, rvalid: 1'b0, count: 5'(i + 1),
                     empty: 1'b0, full: (i == 15), afull: (i >= 13)};
      end
      vecs[16] = '{we: 1'b1, wdata: 32'hDEAD_BEEF, re: 1'b0, rdata: 32'h0, rvalid: 1'b0,
                   count: 5'd16, empty: 1'b0, full: 1'b1, afull: 1'b1};
      for (int j = 0; j < 16; j++) begin
         vecs[17 + j] = '{we: 1'b0, wdata: 32'h0, re: 1'b1,
                          rdata: 32'h1000_0000 + 32'(j), rvalid: 1'b1, count: 5'(15 - j),
                          empty: (j == 15), full: 1'b0, afull: (j <= 1)};
      end

      // Reset held for 2 cycles
      RESET = 1'b1; WE = 1'b0; RE = 1'b0; WDATA = '0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_state("reset", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("reset.afull", 32'(ALMOST_FULL), 32'h0);
      check("reset.ovf", 32'(OVF_ERR), 32'h0);
      check("reset.udf", 32'(UDF_ERR), 32'h0);

      for (int v = 0; v < 33; v++) begin
         step(vecs[v].we, vecs[v].wdata, vecs[v].re);
         check_state($sformatf("vec%0d", v), vecs[v].rdata, vecs[v].rvalid,
                     vecs[v].count, vecs[v].empty, vecs[v].full);
         check($sformatf("vec%0d.afull", v), 32'(ALMOST_FULL), 32'(vecs[v].afull));
      end

      // Wrap: pointers start at 16 after the drain and pass 32 during these rounds
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) step(1'b1, 32'h2000_0000 + 32'(r * 16 + k), 1'b0);
         check($sformatf("wrap%0d.count_full", r), 32'(COUNT), 32'd10);
         for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("wrap%0d.rd%0d", r, k), RDATA, 32'h2000_0000 + 32'(r * 16 + k));
            check($sformatf("wrap%0d.rv%0d", r, k), 32'(RVALID), 32'h1);
         end
      end
      check_state("wrap.end", 32'h2000_0029, 1'b1, 5'd0, 1'b1, 1'b0);

      // Simultaneous on EMPTY: write wins, no bypass
      step(1'b1, 32'hA5A5_A5A5, 1'b1);
      check_state("sim_empty", 32'h0, 1'b0, 5'd1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      check_state("sim_empty.rd", 32'hA5A5_A5A5, 1'b1, 5'd0, 1'b1, 1'b0);

      // Simultaneous on FULL: read wins, write dropped
      for (int i = 0; i < 16; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0);
      check_state("sim_full.pre", 32'h0, 1'b0, 5'd16, 1'b0, 1'b1);
      step(1'b1, 32'hBBBB_BBBB, 1'b1);
      check_state("sim_full", 32'h3000_0000, 1'b1, 5'd15, 1'b0, 1'b0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 32'h0, 1'b1);
         check($sformatf("sim_full.drain%0d", i), RDATA, 32'h3000_0000 + 32'(i));
      end
      check_state("sim_full.end", 32'h3000_000F, 1'b1, 5'd0, 1'b1, 1'b0);

      // Underflow
      step(1'b0, 32'h0, 1'b1);
      check_state("udf", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("udf.udf_err", 32'(UDF_ERR), 32'(ERR_EN));
      check("udf.ovf_err", 32'(OVF_ERR), 32'(ERR_EN));
      step(1'b0, 32'h0, 1'b0);
      check("udf.sticky", 32'(UDF_ERR), 32'(ERR_EN));

      // Mid-operation reset
      for (int i = 0; i < 5; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
      check("midrst.pre_count", 32'(COUNT), 32'd5);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_state("midrst", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("midrst.ovf", 32'(OVF_ERR), 32'h0);
      check("midrst.udf", 32'(UDF_ERR), 32'h0);
      step(1'b0, 32'h0, 1'b1);
      check_state("midrst.rd", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
